// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants for the accumulator CPU
//
// Purpose: machine word width and accumulator source-select encodings shared
//          by the control unit and the accumulator peripherals.
// Ports:   none (package).
package cpu_pkg;

  localparam int WORD_W = 8;

  // Accumulator load source select, driven by the control unit.
  typedef enum logic [1:0] {
    ACC_SRC_ALU = 2'd0,
    ACC_SRC_MEM = 2'd1,
    ACC_SRC_IN  = 2'd2,
    ACC_SRC_IMM = 2'd3
  } acc_src_e;

endpackage

// File: rtl/out_fifo_mem.sv
// rtl/out_fifo_mem.sv - storage array for the accumulator output FIFO
//
// Purpose: DEPTH x DW register array with one synchronous write port and one
//          asynchronous read port. Contents are not reset.
// Ports:   clk   - system clock
//          we    - write enable, sampled on rising clk
//          waddr - write address
//          wdata - write data
//          raddr - read address (asynchronous)
//          rdata - read data
module out_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/acc_out_port.sv
// rtl/acc_out_port.sv - first-word-fall-through FIFO from accumulator to valid/ready port
//
// Purpose: queues accumulator values pushed by storeOut and presents them to an
//          external peripheral over a valid/ready handshake. Pushes into a full
//          FIFO without a same-edge pop are dropped and set a sticky overflow.
// Build option: ACC_OUT_PORT_PARITY_EN adds port_parity (XOR of port_data,
//          computed and stored per entry at push time).
// Ports:   clk         - system clock
//          CLB         - asynchronous active-low clear
//          acc_in      - accumulator value to queue
//          storeOut    - push strobe
//          clrOvf      - synchronous clear of overflow
//          port_data   - head word (0 when empty)
//          port_valid  - port_data is valid
//          port_ready  - peripheral accepts the head word
//          port_parity - even parity of port_data (parity build only)
//          full/empty  - occupancy flags
//          count       - occupied entries
//          overflow    - sticky dropped-push flag
module acc_out_port
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     CLB,
  input  logic [WIDTH-1:0]         acc_in,
  input  logic                     storeOut,
  input  logic                     clrOvf,
  output logic [WIDTH-1:0]         port_data,
  output logic                     port_valid,
  input  logic                     port_ready,
`ifdef ACC_OUT_PORT_PARITY_EN
  output logic                     port_parity,
`endif
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef ACC_OUT_PORT_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic          drop;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign port_valid = ~empty;

  // A pop on the same edge frees a slot, so a full FIFO still accepts a push.
  assign pop  = port_valid & port_ready;
  assign push = storeOut & (~full | pop);
  assign drop = storeOut & full & ~pop;

`ifdef ACC_OUT_PORT_PARITY_EN
  assign wdata = {^acc_in, acc_in};
`else
  assign wdata = acc_in;
`endif

  out_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is not cleared, so mask the read port while empty to keep the
  // port at zero after reset and between bursts.
  assign port_data = port_valid ? rdata[WIDTH-1:0] : '0;
`ifdef ACC_OUT_PORT_PARITY_EN
  assign port_parity = port_valid & rdata[WIDTH];
`endif

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // Pointers are PW bits wide; DEPTH is a power of two so +1 wraps to 0.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      // A dropped push wins over a same-edge clear.
      if (drop)        ovf_q <= 1'b1;
      else if (clrOvf) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_out_port.sv
// tb/tb_acc_out_port.sv - directed self-checking bench for acc_out_port
module tb_acc_out_port;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             CLB;
  logic [WIDTH-1:0] acc_in;
  logic             storeOut;
  logic             clrOvf;
  logic [WIDTH-1:0] port_data;
  logic             port_valid;
  logic             port_ready;
`ifdef ACC_OUT_PORT_PARITY_EN
  logic             port_parity;
`endif
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  acc_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .CLB        (CLB),
    .acc_in     (acc_in),
    .storeOut   (storeOut),
    .clrOvf     (clrOvf),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_ready (port_ready),
`ifdef ACC_OUT_PORT_PARITY_EN
    .port_parity(port_parity),
`endif
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    storeOut = 1'b1;
    acc_in   = w;
    tick();
    storeOut = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", port_valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (port_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", port_data); end
    #5 CLB = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    port_ready = 1'b0;
    push_word(8'h3C);
    checks++; if (port_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", port_valid); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", count); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (port_data !== 8'h3C) begin failures++; $display("FAIL lat_hold%0d got=%h exp=3c", i, port_data); end
      tick();
    end
    port_ready = 1'b1;
    tick();
    port_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL lat_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_overflow;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    push_word(8'h05);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count_after_drop got=%0d exp=4", count); end
    clrOvf = 1'b1;
    push_word(8'h06);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop_beats_clr got=%b exp=1", overflow); end
    tick();
    clrOvf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    port_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (port_data !== 8'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, port_data, 8'(i)); end
      tick();
    end
    port_ready = 1'b0;
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain_done got=%b exp=0", port_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h12; exp_q[1] = 8'h13; exp_q[2] = 8'h14; exp_q[3] = 8'hAA;
    for (int i = 1; i <= 4; i++) push_word(8'h10 + 8'(i));
    port_ready = 1'b1;
    push_word(8'hAA);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (port_data !== exp_q[i]) begin failures++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, port_data, exp_q[i]); end
      tick();
    end
    port_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_stream;
    port_ready = 1'b1;
    storeOut   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc_in = 8'h50 + 8'(i);
      tick();
      checks++; if (port_data !== 8'h50 + 8'(i)) begin failures++; $display("FAIL stream_data%0d got=%h exp=%h", i, port_data, 8'h50 + 8'(i)); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count%0d got=%0d exp=1", i, count); end
    end
    storeOut = 1'b0;
    tick();
    port_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL stream_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid;
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rst_pre_count got=%0d exp=3", count); end
    #2 CLB = 1'b0;
    #1;
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", port_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", count); end
    checks++; if (port_data !== 8'h00) begin failures++; $display("FAIL rst_async_data got=%h exp=00", port_data); end
    #1 CLB = 1'b1;
    port_ready = 1'b1;
    tick();
    tick();
    checks++; if (port_valid !== 1'b0) begin failures++; $display("FAIL rst_after_valid got=%b exp=0", port_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_ready_empty_count got=%0d exp=0", count); end
    port_ready = 1'b0;
  endtask

`ifdef ACC_OUT_PORT_PARITY_EN
  task automatic test_parity;
    port_ready = 1'b0;
    push_word(8'h07);
    checks++; if (port_parity !== 1'b1) begin failures++; $display("FAIL par_07 got=%b exp=1", port_parity); end
    port_ready = 1'b1;
    push_word(8'h03);
    checks++; if (port_parity !== 1'b0) begin failures++; $display("FAIL par_03 got=%b exp=0", port_parity); end
    tick();
    port_ready = 1'b0;
  endtask
`endif

  initial begin
    CLB        = 1'b0;
    acc_in     = '0;
    storeOut   = 1'b0;
    clrOvf     = 1'b0;
    port_ready = 1'b0;
    test_reset();
    test_latency();
    test_full_overflow();
    test_full_push_pop();
    test_stream();
    test_reset_mid();
`ifdef ACC_OUT_PORT_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_out_port.md
ACC_OUT_PORT -- requirements
Module: acc_out_port

Interface
REQ-001 Parameter WIDTH, default 8, data word width (matches accumulator width).
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 CLB  input  1  asynchronous active-low clear.
REQ-005 acc_in  input  WIDTH  accumulator value to be sent off-chip.
REQ-006 storeOut  input  1  push strobe from control unit; sampled on rising clk.
REQ-007 clrOvf  input  1  synchronous clear of the overflow flag.
REQ-008 port_data  output  WIDTH  word presented to the external peripheral.
REQ-009 port_valid  output  1  port_data holds a valid word.
REQ-010 port_ready  input  1  peripheral accepts the word this cycle.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  clog2(DEPTH)+1  occupied entries.
REQ-014 overflow  output  1  sticky flag: a push was dropped.

Function
REQ-015 Block SHALL be a first-word-fall-through FIFO draining accumulator writes to a valid/ready output port.
REQ-016 Push SHALL occur on a rising edge when storeOut=1 and (full=0 or a pop occurs on the same edge).
REQ-017 Pop SHALL occur on a rising edge when port_valid=1 and port_ready=1.
REQ-018 port_valid SHALL equal not empty; port_data SHALL equal the head entry, driven from registers.
REQ-019 Latency: push into an empty FIFO at edge N SHALL make port_valid=1 with that word from edge N onward (visible cycle N+1).
REQ-020 While port_valid=1 and port_ready=0, port_data SHALL remain stable.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; on one-entry FIFO the pushed word SHALL become head after the edge.
REQ-022 Push when full with no pop SHALL be discarded, FIFO contents unchanged, overflow set to 1 on that edge.
REQ-023 overflow SHALL remain 1 until clrOvf=1 on an edge or reset; a simultaneous dropped push and clrOvf SHALL leave overflow=1.
REQ-024 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-025 port_ready with port_valid=0 SHALL have no effect.
REQ-026 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-027 CLB=0 SHALL immediately, without clk, set pointers=0, count=0, empty=1, full=0, port_valid=0, overflow=0, port_data=0.
REQ-028 Reset mid-transfer SHALL discard all queued words; no word SHALL be presented after release until a new push.
REQ-029 Storage array contents need not be cleared.

Configuration
REQ-030 Macro ACC_OUT_PORT_PARITY_EN, when defined, SHALL add output port_parity (1 bit) equal to even parity (XOR) of port_data, stored per entry at push time.
REQ-031 Without ACC_OUT_PORT_PARITY_EN, port_parity and its storage SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package cpu_pkg SHALL hold WORD_W=8 and the accumulator source-select constants; WIDTH defaults to WORD_W.
REQ-033 Storage SHALL be a sub-module out_fifo_mem (write port, asynchronous read port indexed by read pointer); pointer/flag control stays in acc_out_port.

Verification
REQ-034 Reset, push 0x3C with port_ready=0 -> next cycle port_valid=1, port_data=0x3C, count=1, held stable 5 cycles.
REQ-035 Push 0x01,0x02,0x03,0x04 (DEPTH=4), port_ready=0 -> full=1, count=4; push 0x05 -> dropped, overflow=1; drain order 0x01..0x04.
REQ-036 Full FIFO, push 0xAA with port_ready=1 same edge -> count stays 4, overflow stays 0, 0xAA output last.
REQ-037 Stream 10 pushes with port_ready=1 continuously -> 10 words out in order, pointers wrap, count never >1.
REQ-038 Three words queued, CLB pulsed low between edges -> outputs cleared immediately, port_valid=0 after release.
REQ-039 With ACC_OUT_PORT_PARITY_EN, push 0x07 -> port_parity=1; push 0x03 -> port_parity=0.
